// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: groups the UART strobe side and the CPU I/O-page side of the
// receive FIFO into one bundle. The master modport belongs to whoever drives the
// UART byte strobe and the CPU bus (the system, or a testbench). The slave modport
// belongs to the FIFO itself.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      rx_data;
  logic            rx_push;
  logic [7:0]      access_addr;
  logic            reg_w_en;
  logic            mem_w_en;
  logic [7:0]      w_data;
  logic [7:0]      r_data;
  logic            hit;
  logic [ADDR_W:0] count;
  logic            int_req;

  modport master (
    output rx_data, rx_push, access_addr, reg_w_en, mem_w_en, w_data,
    input  r_data, hit, count, int_req
  );

  modport slave (
    input  rx_data, rx_push, access_addr, reg_w_en, mem_w_en, w_data,
    output r_data, hit, count, int_req
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular receive buffer between the UART receiver and the CPU.
// Bytes strobed by the UART are queued. The CPU pops the head through the data
// register and controls or inspects the FIFO through the control/status register.
// A registered, level-sensitive interrupt request is driven toward the CPU.
// Optional feature macro: UART_RX_FIFO_THRESH_INT_EN adds a threshold register at
// CTRL_ADDR-1. The interrupt then fires on (count >= thresh) | overrun.
module uart_rx_fifo #(
  parameter int          DEPTH     = 16,
  parameter int          ADDR_W    = 4,
  parameter logic [7:0]  DATA_ADDR = 8'd252,
  parameter logic [7:0]  CTRL_ADDR = 8'd248
) (
  input logic           clock,
  input logic           reset_n,
  uart_rx_fifo_if.slave bus
);

  // Storage and state
  logic [7:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic            overrun_reg, overrun_next;
  logic            int_en_reg, int_en_next;
  logic            int_req_reg, int_req_next;

  // Decode and handshake terms
  logic            empty, full;
  logic            data_sel, ctrl_sel;
  logic            ctrl_wr, flush;
  logic            pop, push, overrun_set;
  logic            irq_cond;
  logic [7:0]      status_byte;
  logic [7:0]      head_byte;
  logic            ctrl_unused;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (ADDR_W+1)'(DEPTH));
  assign data_sel = (bus.access_addr == DATA_ADDR);
  assign ctrl_sel = (bus.access_addr == CTRL_ADDR);
  assign ctrl_wr  = ctrl_sel & bus.mem_w_en;
  assign flush    = ctrl_wr & bus.w_data[1];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a byte
  // when the CPU is popping at the same time.
  assign pop         = data_sel & bus.reg_w_en & ~empty;
  assign push        = bus.rx_push & (~full | pop);
  assign overrun_set = bus.rx_push & full & ~pop;

  assign status_byte = {int_en_reg, 4'b0000, overrun_reg, full, ~empty};
  assign head_byte   = empty ? 8'h00 : mem[rd_ptr_reg];

  // Bits 6..2 of a control write carry no meaning.
  assign ctrl_unused = ^bus.w_data[6:2];

`ifdef UART_RX_FIFO_THRESH_INT_EN
  localparam logic [7:0] THRESH_ADDR = CTRL_ADDR - 8'd1;

  logic       thresh_sel;
  logic [7:0] thresh_reg, thresh_next;
  logic [7:0] thresh_eff;

  assign thresh_sel = (bus.access_addr == THRESH_ADDR);
  // A zero threshold would fire with an empty FIFO, so treat it as one.
  assign thresh_eff = (thresh_reg == 8'd0) ? 8'd1 : thresh_reg;
  assign irq_cond   = (9'(count_reg) >= {1'b0, thresh_eff}) | overrun_reg;

  // Threshold register next value
  always_comb begin
    thresh_next = thresh_reg;
    if (thresh_sel && bus.mem_w_en) begin
      thresh_next = bus.w_data;
    end
  end

  // Threshold register, resets to one
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      thresh_reg <= 8'd1;
    end else begin
      thresh_reg <= thresh_next;
    end
  end

  // Read mux and hit for the three decoded addresses
  always_comb begin
    bus.r_data = 8'h00;
    bus.hit    = data_sel | ctrl_sel | thresh_sel;
    if (data_sel) begin
      bus.r_data = head_byte;
    end else if (ctrl_sel) begin
      bus.r_data = status_byte;
    end else if (thresh_sel) begin
      bus.r_data = thresh_reg;
    end
  end
`else
  assign irq_cond = ~empty;

  // Read mux and hit for the two decoded addresses
  always_comb begin
    bus.r_data = 8'h00;
    bus.hit    = data_sel | ctrl_sel;
    if (data_sel) begin
      bus.r_data = head_byte;
    end else if (ctrl_sel) begin
      bus.r_data = status_byte;
    end
  end
`endif

  // Per-entry write: each slot captures the byte when it is the tail and a push lands.
  // Contents are intentionally not reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clock) begin
        if (push && !flush && (wr_ptr_reg == ADDR_W'(gi))) begin
          mem[gi] <= bus.rx_data;
        end
      end
    end
  endgenerate

  // Next-state for pointers, count, flags and interrupt request. A flush overrides
  // any push or pop in the same cycle. A new overrun wins over a clear.
  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    count_next   = count_reg;
    overrun_next = overrun_reg;
    int_en_next  = int_en_reg;
    int_req_next = int_en_reg & irq_cond;

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
      end
      if (push && !pop) begin
        count_next = count_reg + (ADDR_W+1)'(1);
      end else if (pop && !push) begin
        count_next = count_reg - (ADDR_W+1)'(1);
      end
    end

    if (overrun_set) begin
      overrun_next = 1'b1;
    end else if (ctrl_wr && bus.w_data[0]) begin
      overrun_next = 1'b0;
    end

    if (ctrl_wr) begin
      int_en_next = bus.w_data[7];
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
      int_en_reg  <= 1'b0;
      int_req_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      overrun_reg <= overrun_next;
      int_en_reg  <= int_en_next;
      int_req_reg <= int_req_next;
    end
  end

  assign bus.count   = count_reg;
  assign bus.int_req = int_req_reg;

endmodule
